// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack channel plus the
// instruction/resolution handshake with the control unit.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        ctrl_valid;
    logic        branch;
    logic        jump;
    logic        taken;
    logic [31:0] pc;
    logic [31:0] link_addr;

    modport master (
        output imem_req, imem_addr, instr, instr_valid, pc, link_addr,
        input  imem_ack, imem_rdata, instr_ready, ctrl_valid, branch, jump, taken
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, pc, link_addr,
        output imem_ack, imem_rdata, instr_ready, ctrl_valid, branch, jump, taken
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// BUBBLE instruction fetch and PC sequencer: fetch one word, issue it, wait for
// its branch/jump resolution, then fetch from the resolved next PC.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master bus
);
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        ISSUE   = 2'd2,
        RESOLVE = 2'd3
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] imem_addr_q;
    logic        imem_req_q;
    logic        instr_valid_q;
    logic [31:0] pc_plus4;
    logic [31:0] pc_d;

    function automatic logic [31:0] branch_target(input logic [31:0] base,
                                                  input logic [15:0] imm);
        logic signed [31:0] offset;
        offset = {{14{imm[15]}}, imm, 2'b00};
        return base + $unsigned(offset);
    endfunction

    function automatic logic [31:0] jump_target(input logic [31:0] base,
                                                input logic [25:0] index);
        return {base[31:28], index, 2'b00};
    endfunction

    assign pc_plus4 = pc_q + 32'd4;

    // jump outranks branch; taken only matters for a branch
    always_comb begin
        pc_d = pc_plus4;
        if (bus.jump) begin
            pc_d = jump_target(pc_plus4, instr_q[25:0]);
        end else if (bus.branch && bus.taken) begin
            pc_d = branch_target(pc_plus4, instr_q[15:0]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC_ALIGNED;
            instr_q       <= 32'd0;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= 32'd0;
            instr_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q     <= FETCH;
                    imem_req_q  <= 1'b1;
                    imem_addr_q <= pc_q;
                end
                FETCH: begin
                    if (bus.imem_ack) begin
                        instr_q       <= bus.imem_rdata;
                        state_q       <= ISSUE;
                        imem_req_q    <= 1'b0;
                        imem_addr_q   <= 32'd0;
                        instr_valid_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (bus.instr_ready) begin
                        state_q       <= RESOLVE;
                        instr_valid_q <= 1'b0;
                    end
                end
                RESOLVE: begin
                    if (bus.ctrl_valid) begin
                        pc_q        <= pc_d;
                        state_q     <= FETCH;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= pc_d;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    imem_req_q    <= 1'b0;
                    imem_addr_q   <= 32'd0;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = imem_addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.pc          = pc_q;
    assign bus.link_addr   = pc_plus4;
endmodule
